// File: rtl/sr_flag_arb_pkg.sv
// Shared definitions for the set/reset flag arbiter: op encodings and FSM states.
package sr_pkg;
    localparam logic [1:0] OP_HOLD = 2'b00;
    localparam logic [1:0] OP_CLR  = 2'b01;
    localparam logic [1:0] OP_SET  = 2'b10;
    localparam logic [1:0] OP_BAD  = 2'b11;

    typedef enum logic {ST_IDLE, ST_GRANT} st_e;
endpackage

// File: rtl/sr_flag_arb_if.sv
// Requester-side bus of the flag arbiter; master = requesters, slave = the block.
interface sr_flag_arb_if #(
    parameter int NREQ  = 4,
    parameter int NFLAG = 8
);
    localparam int IDXW = $clog2(NFLAG);
    localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic                   en;
    logic [NREQ-1:0]        req;
    logic [NREQ-1:0]        s;
    logic [NREQ-1:0]        r;
    logic [NREQ*IDXW-1:0]   idx;
    logic [NREQ-1:0]        gnt;
    logic [NFLAG-1:0]       flags;
    logic                   err;
    logic [PW-1:0]          err_id;

    modport master (output en, req, s, r, idx, input gnt, flags, err, err_id);
    modport slave  (input en, req, s, r, idx, output gnt, flags, err, err_id);
endinterface

// File: rtl/sr_flag_arb_rr.sv
// Combinational round-robin pick: first eligible requester at or after ptr, wrapping.
module rr_arb #(
    parameter  int N  = 4,
    localparam int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  eligible,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  win,
    output logic [PW-1:0] win_id,
    output logic          any
);
    logic w_found;
    int   w_j;

    always_comb begin
        win     = '0;
        win_id  = '0;
        w_found = 1'b0;
        w_j     = 0;
        for (int i = 0; i < N; i++) begin
            w_j = (int'(ptr) + i) % N;
            if (!w_found && eligible[w_j]) begin
                w_found  = 1'b1;
                win[w_j] = 1'b1;
                win_id   = PW'(w_j);
            end
        end
    end

    assign any = |eligible;
endmodule

// File: rtl/sr_flag_arb.sv
// Round-robin arbiter that applies one granted set/clear/hold op per cycle to a flag bank.
module sr_flag_arb
    import sr_pkg::*;
#(
    parameter  int NREQ  = 4,
    parameter  int NFLAG = 8,
    localparam int IDXW  = $clog2(NFLAG),
    localparam int PW    = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic         clk,
    input  logic         rst,
    sr_flag_arb_if.slave bus
);
    st_e              r_st, w_st_nxt;
    logic [NREQ-1:0]  r_gnt, w_gnt_nxt;
    logic [PW-1:0]    r_ptr, w_ptr_nxt;
    logic [NFLAG-1:0] r_flags;
    logic             r_err;
    logic [PW-1:0]    r_err_id;

    logic [NREQ-1:0]  w_elig, w_win;
    logic [PW-1:0]    w_win_id;
    logic             w_any, w_go, w_bad;
    logic [1:0]       w_op;
    logic [IDXW-1:0]  w_idx;

    // A requester still showing its grant pulse sits out one cycle.
    assign w_elig = bus.req & ~r_gnt;

    rr_arb #(.N(NREQ)) u_rr (
        .eligible (w_elig),
        .ptr      (r_ptr),
        .win      (w_win),
        .win_id   (w_win_id),
        .any      (w_any)
    );

    assign w_go      = bus.en & w_any;
    assign w_op      = {bus.s[w_win_id], bus.r[w_win_id]};
    assign w_idx     = bus.idx[w_win_id*IDXW +: IDXW];
    assign w_bad     = (w_op == OP_BAD) || (32'(w_idx) >= NFLAG);
    assign w_ptr_nxt = (w_win_id == PW'(NREQ - 1)) ? '0 : w_win_id + 1'b1;

    always_comb begin
        w_st_nxt  = ST_IDLE;
        w_gnt_nxt = '0;
        case (r_st)
            ST_IDLE:  if (w_go) w_st_nxt = ST_GRANT;
            ST_GRANT: if (w_go) w_st_nxt = ST_GRANT;
            default:  w_st_nxt = ST_IDLE;
        endcase
        if (w_st_nxt == ST_GRANT) w_gnt_nxt = w_win;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_st     <= ST_IDLE;
            r_gnt    <= '0;
            r_ptr    <= '0;
            r_flags  <= '0;
            r_err    <= 1'b0;
            r_err_id <= '0;
        end else begin
            r_st  <= w_st_nxt;
            r_gnt <= w_gnt_nxt;
            r_err <= w_go & w_bad;
            if (w_go) begin
                r_ptr <= w_ptr_nxt;
                if (w_bad)
                    r_err_id <= w_win_id;
                else if (w_op == OP_SET)
                    r_flags[w_idx] <= 1'b1;
                else if (w_op == OP_CLR)
                    r_flags[w_idx] <= 1'b0;
            end
        end
    end

    assign bus.gnt    = r_gnt;
    assign bus.flags  = r_flags;
    assign bus.err    = r_err;
    assign bus.err_id = r_err_id;
endmodule

// File: tb/tb_sr_flag_arb.sv
// Directed bench for sr_flag_arb: main instance NFLAG=8, second instance NFLAG=6 for range errors.
module tb_sr_flag_arb;
    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    sr_flag_arb_if #(.NREQ(4), .NFLAG(8)) b1 ();
    sr_flag_arb_if #(.NREQ(4), .NFLAG(6)) b2 ();

    sr_flag_arb #(.NREQ(4), .NFLAG(8)) dut  (.clk(clk), .rst(rst), .bus(b1));
    sr_flag_arb #(.NREQ(4), .NFLAG(6)) dut2 (.clk(clk), .rst(rst), .bus(b2));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic put(input int k, input bit rq, input bit ss, input bit rr, input int ix);
        b1.req[k] = rq;
        b1.s[k]   = ss;
        b1.r[k]   = rr;
        b1.idx[k*3 +: 3] = 3'(ix);
    endtask

    task automatic put2(input int k, input bit rq, input bit ss, input bit rr, input int ix);
        b2.req[k] = rq;
        b2.s[k]   = ss;
        b2.r[k]   = rr;
        b2.idx[k*3 +: 3] = 3'(ix);
    endtask

    initial begin
        rst = 1'b1;
        b1.en = 1'b0; b1.req = '0; b1.s = '0; b1.r = '0; b1.idx = '0;
        b2.en = 1'b0; b2.req = '0; b2.s = '0; b2.r = '0; b2.idx = '0;
        tick(); tick();
        chk("rst_gnt", b1.gnt, 0);
        chk("rst_flags", b1.flags, 0);
        chk("rst_err", b1.err, 0);
        chk("rst_err_id", b1.err_id, 0);
        rst = 1'b0;

        // single SET then CLR on flag 5 by requester 2
        b1.en = 1'b1;
        put(2, 1, 1, 0, 5);
        tick();
        chk("set_gnt", b1.gnt, 4'b0100);
        chk("set_flags", b1.flags, 8'h20);
        chk("set_err", b1.err, 0);
        put(2, 1, 0, 1, 5);
        tick();
        chk("gap_gnt", b1.gnt, 0);
        chk("gap_flags", b1.flags, 8'h20);
        tick();
        chk("clr_gnt", b1.gnt, 4'b0100);
        chk("clr_flags", b1.flags, 8'h00);
        put(2, 0, 0, 0, 0);
        tick();
        chk("idle_gnt", b1.gnt, 0);

        // reset to put ptr back at 0, then full round-robin with all HOLD
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int k = 0; k < 4; k++) put(k, 1, 0, 0, 0);
        tick(); chk("rr0", b1.gnt, 4'b0001);
        tick(); chk("rr1", b1.gnt, 4'b0010);
        tick(); chk("rr2", b1.gnt, 4'b0100);
        tick(); chk("rr3", b1.gnt, 4'b1000);
        tick(); chk("rr4", b1.gnt, 4'b0001);
        chk("rr_flags", b1.flags, 8'h00);
        for (int k = 0; k < 4; k++) put(k, 0, 0, 0, 0);
        tick(); chk("rr_end", b1.gnt, 0);

        // s=r=1 is rejected
        put(3, 1, 1, 1, 2);
        tick();
        chk("bad_gnt", b1.gnt, 4'b1000);
        chk("bad_err", b1.err, 1);
        chk("bad_err_id", b1.err_id, 3);
        chk("bad_flags", b1.flags, 8'h00);
        put(3, 0, 0, 0, 0);
        tick();
        chk("bad_err_pulse", b1.err, 0);
        chk("bad_err_id_hold", b1.err_id, 3);

        // enable gating: requests wait, flags hold
        b1.en = 1'b0;
        put(0, 1, 1, 0, 0);
        put(1, 1, 1, 0, 1);
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("en0_gnt", b1.gnt, 0);
            chk("en0_flags", b1.flags, 8'h00);
        end
        b1.en = 1'b1;
        tick();
        chk("en1_gnt0", b1.gnt, 4'b0001);
        chk("en1_flags0", b1.flags, 8'h01);
        put(0, 0, 0, 0, 0);
        tick();
        chk("en1_gnt1", b1.gnt, 4'b0010);
        chk("en1_flags1", b1.flags, 8'h03);
        put(1, 0, 0, 0, 0);
        tick();

        // fill the bank; last grant to requester 1 leaves ptr=2
        for (int i = 2; i < 8; i++) begin
            put((i + 2) % 4, 1, 1, 0, i);
            tick();
            chk("fill_gnt", b1.gnt, 32'(1 << ((i + 2) % 4)));
            put((i + 2) % 4, 0, 0, 0, 0);
        end
        chk("fill_flags", b1.flags, 8'hFF);

        // reset with requests 1 and 3 pending: arbitration restarts at ptr=0
        put(1, 1, 0, 0, 0);
        put(3, 1, 0, 0, 0);
        rst = 1'b1;
        tick();
        chk("mid_rst_flags", b1.flags, 8'h00);
        chk("mid_rst_gnt", b1.gnt, 0);
        rst = 1'b0;
        tick();
        chk("post_rst_gnt", b1.gnt, 4'b0010);
        put(1, 0, 0, 0, 0);
        tick();
        chk("post_rst_gnt2", b1.gnt, 4'b1000);
        put(3, 0, 0, 0, 0);
        tick();

        // back-to-back SET/CLR on the same flag
        put(0, 1, 1, 0, 3);
        put(1, 1, 0, 1, 3);
        tick();
        chk("b2b_gnt0", b1.gnt, 4'b0001);
        chk("b2b_flag_set", b1.flags[3], 1);
        put(0, 0, 0, 0, 0);
        tick();
        chk("b2b_gnt1", b1.gnt, 4'b0010);
        chk("b2b_flag_clr", b1.flags[3], 0);
        put(1, 0, 0, 0, 0);

        // out-of-range index on a 6-flag bank
        b2.en = 1'b1;
        put2(1, 1, 1, 0, 7);
        tick();
        chk("oor_gnt", b2.gnt, 4'b0010);
        chk("oor_err", b2.err, 1);
        chk("oor_err_id", b2.err_id, 1);
        chk("oor_flags", b2.flags, 6'h00);
        put2(1, 0, 0, 0, 0);
        put2(2, 1, 1, 0, 5);
        tick();
        chk("top_idx_gnt", b2.gnt, 4'b0100);
        chk("top_idx_err", b2.err, 0);
        chk("top_idx_flags", b2.flags, 6'h20);
        put2(2, 0, 0, 0, 0);
        put2(3, 1, 1, 0, 6);
        tick();
        chk("eq_nflag_err", b2.err, 1);
        chk("eq_nflag_err_id", b2.err_id, 3);
        chk("eq_nflag_flags", b2.flags, 6'h20);
        put2(3, 0, 0, 0, 0);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
